// File: rtl/btn_pkg.sv
// Shared types and default constants for the button debouncer.
package btn_pkg;

  // Debouncer FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

endpackage : btn_pkg

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Reusable by any input block; STAGES must be at least 2.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the flop chain; clear the chain on reset.
  // NOTE: these flops are reset on purpose so the FSM never sees a stale
  // level after reset; large storage arrays would normally be left unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignment makes every stage take the previous
      // stage's old value, which is exactly what a shift chain needs.
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule : sync_ff

// File: rtl/button_debounce.sv
// Debouncer for a mechanical push button: synchronize the raw level, then
// only accept a new level after it has been stable for DEBOUNCE_CYCLES
// consecutive samples. db_o is registered; busy_o marks a qualification.
module button_debounce
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic db_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // A one-sample qualification needs no wait state at all.
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic             w_btn_s;
  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_db;
  logic             w_db_nxt;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_i),
    .q_o   (w_btn_s)
  );

  // Next-state, counter and output-level decision from the synchronized level.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned (which would infer a latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_db_nxt    = r_db;
    unique case (r_state)
      IDLE_LOW: begin
        if (w_btn_s) begin
          if (SINGLE) begin
            w_state_nxt = IDLE_HIGH;
            w_db_nxt    = 1'b1;
          end else begin
            w_state_nxt = WAIT_HIGH;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_db_nxt    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!w_btn_s) begin
          if (SINGLE) begin
            w_state_nxt = IDLE_LOW;
            w_db_nxt    = 1'b0;
          end else begin
            w_state_nxt = WAIT_LOW;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (w_btn_s) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_db_nxt    = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
        w_db_nxt    = 1'b0;
      end
    endcase
  end

  // State, counter and debounced level registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_db    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
    end
  end

  assign db_o   = r_db;
  assign busy_o = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
// plus a DEBOUNCE_CYCLES=1 instance driven by the same button.
module tb_button_debounce;

  localparam int S = 2;
  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn_i = 1'b0;
  logic db_o, busy_o;
  logic db1_o, busy1_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_i),
    .db_o   (db_o),
    .busy_o (busy_o)
  );

  button_debounce #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (1)
  ) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_i),
    .db_o   (db1_o),
    .busy_o (busy1_o)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the level seen by the debouncer is the input delayed by
  // S samples; db flips once that level has differed from db for D
  // consecutive samples, and busy means a differing run is in progress.
  logic m_pipe [S];
  logic m_seen;
  int   m_run    = 0;
  logic m_db     = 1'b0;
  bit   m_valid  = 1'b0;
  int   rise_cnt = 0;
  logic prev_db  = 1'b0;

  always begin
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < S; i++) m_pipe[i] = 1'b0;
      m_run   = 0;
      m_db    = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_seen = m_pipe[S-1];
      for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = btn_i;
      if (m_seen != m_db) begin
        m_run++;
        if (m_run == D) begin
          m_db  = m_seen;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    if (m_valid) begin
      check("model_db", db_o, m_db);
      check("model_busy", busy_o, (m_run > 0));
      check("d1_busy", busy1_o, 1'b0);
      if (db_o && !prev_db) rise_cnt++;
      prev_db = db_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  logic [4:0] bounce5;
  logic [7:0] bounce8;

  initial begin
    // Reset with the button pressed: reset must win.
    rst_n = 1'b0;
    btn_i = 1'b1;
    idle(3);
    #2;
    check("rst_db", db_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_db1", db1_o, 1'b0);
    @(negedge clk);
    btn_i = 1'b0;
    rst_n = 1'b1;
    idle(4);

    // Clean press held: db rises on edge 6, busy on edges 3..5.
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      btn_i = 1'b1;
      @(posedge clk);
      #2;
      check("press_db", db_o, (e >= 6));
      check("press_busy", busy_o, (e >= 3 && e <= 5));
      check("press_db1", db1_o, (e >= 3));
    end
    @(negedge clk);
    btn_i = 1'b0;
    idle(10);

    // Three-cycle pulse: rejected.
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      btn_i = (e <= 3);
      @(posedge clk);
      #2;
      check("short_db", db_o, 1'b0);
    end
    check("short_busy", busy_o, 1'b0);

    // Exactly four cycles: db rises at edge 6, falls at edge 10.
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      btn_i = (e <= 4);
      @(posedge clk);
      #2;
      check("exact_db", db_o, (e >= 6 && e <= 9));
      check("exact_db1", db1_o, (e >= 3 && e <= 6));
    end
    idle(4);

    // Bounce 1,0,1,0,1 then held: final rise sampled at edge 5, db at edge 10.
    bounce5 = 5'b10101;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      btn_i = (e <= 5) ? bounce5[5-e] : 1'b1;
      @(posedge clk);
      #2;
      check("bounce_db", db_o, (e >= 10));
    end
    @(negedge clk);
    btn_i = 1'b0;
    idle(10);

    // Reset during WAIT_HIGH with the button held.
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      btn_i = 1'b1;
      @(posedge clk);
      #2;
      check("pre_rst_busy", busy_o, (e >= 3));
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check("mid_rst_db", db_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      @(posedge clk);
      #2;
      check("post_rst_db", db_o, (r >= 6));
    end
    @(negedge clk);
    btn_i = 1'b0;
    idle(10);

    // Bouncy 40-cycle press with bouncy release: exactly one rising edge.
    @(negedge clk);
    rise_cnt = 0;
    bounce8  = 8'b10110100;
    for (int c = 0; c < 40; c++) begin
      btn_i = (c < 8) ? bounce8[7-c] : 1'b1;
      @(negedge clk);
    end
    bounce5 = 5'b01000;
    for (int c = 0; c < 20; c++) begin
      btn_i = (c < 5) ? bounce5[4-c] : 1'b0;
      @(negedge clk);
    end
    idle(4);
    #2;
    n_vec++;
    if (rise_cnt != 1) begin
      n_err++;
      $display("FAIL chain_pulses: got %0d expected 1", rise_cnt);
    end
    check("chain_end_db", db_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_button_debounce

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on btn_i; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable samples required before db_o changes; legal range 1..2^24.
REQ-003 Port clk, input, 1: single clock for the whole block; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port btn_i, input, 1: raw, asynchronous, bouncing mechanical button level (1 = pressed).
REQ-006 Port db_o, output, 1: debounced button level; feeds the downstream Buttonpulse edge detector directly.
REQ-007 Port busy_o, output, 1: high while a level change is being qualified, i.e. the FSM is in WAIT_HIGH or WAIT_LOW.

Function
REQ-008 btn_i SHALL pass through SYNC_STAGES flops; the last stage is btn_s, and only btn_s SHALL feed the FSM.
REQ-009 The FSM SHALL have four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-010 IDLE_LOW: db_o=0; if btn_s=1, go to WAIT_HIGH with cnt=1; otherwise stay.
REQ-011 WAIT_HIGH: if btn_s=0, return to IDLE_LOW with cnt=0 (glitch rejected); if btn_s=1 and cnt=DEBOUNCE_CYCLES-1, go to IDLE_HIGH and set db_o=1; otherwise cnt+1.
REQ-012 IDLE_HIGH and WAIT_LOW SHALL mirror REQ-010/011 with the polarity inverted; db_o is cleared on entry to IDLE_LOW from WAIT_LOW.
REQ-013 If DEBOUNCE_CYCLES=1, the FSM SHALL transition straight from IDLE_LOW to IDLE_HIGH (and back), skipping the WAIT states; busy_o then stays 0.
REQ-014 Latency: db_o SHALL change on the edge numbered SYNC_STAGES+DEBOUNCE_CYCLES, where edge 1 is the first edge that samples btn_i at its new level and btn_i holds that level throughout.
REQ-015 A btn_s excursion of at most DEBOUNCE_CYCLES-1 cycles SHALL NOT change db_o; an excursion of exactly DEBOUNCE_CYCLES cycles SHALL change it.
REQ-016 Counter width CNT_W SHALL be $clog2(DEBOUNCE_CYCLES+1); cnt SHALL never wrap, being cleared on every return to an IDLE state.
REQ-017 db_o SHALL be a register; busy_o SHALL be decoded only from the state register; there SHALL be no combinational path from btn_i to any output.
REQ-018 db_o SHALL change at most once per qualification and never toggles in the same cycle that busy_o rises.

Reset
REQ-019 When rst_n=0 at a clock edge: all synchronizer flops=0, state=IDLE_LOW, cnt=0, db_o=0, busy_o=0.
REQ-020 Reset asserted mid-qualification SHALL abandon the qualification; if btn_i is held at 1 through reset, db_o SHALL rise the full REQ-014 latency after the first edge with rst_n=1.
REQ-021 rst_n SHALL override btn_i activity on the same edge.

Structure
REQ-022 Package btn_pkg SHALL hold the FSM state enum (2-bit encoding) and the default constants SYNC_STAGES_DEF=2 and DEBOUNCE_CYCLES_DEF=500000.
REQ-023 The synchronizer SHALL be a separate sub-module, sync_ff (parameter STAGES, ports clk, rst_n, d_i, q_o), reusable by other input blocks.
REQ-024 The top level SHALL contain only sync_ff, the FSM and the counter.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-025 btn_i 0->1 held steady -> db_o rises on edge 6; busy_o is high from edge 3 through edge 5.
REQ-026 btn_i high for 3 cycles then low -> db_o stays 0; busy_o returns to 0; cnt=0.
REQ-027 btn_i high for exactly 4 cycles then low -> db_o rises, then falls 6 edges after the falling input is first sampled.
REQ-028 Bouncing input (1,0,1,0,1 single cycles, then held high) -> db_o rises exactly 6 edges after the final 0->1 is sampled, with no earlier toggle.
REQ-029 rst_n=0 for 1 cycle during WAIT_HIGH while btn_i is held at 1 -> db_o=0, state=IDLE_LOW; db_o rises 6 edges after rst_n returns to 1.
REQ-030 Chained with Buttonpulse, a bouncy 40-cycle press -> exactly one out_o pulse.
